// File: rtl/div_radix2_stall_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_radix2_stall_if : EX-stage divider request/stall/result bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface div_radix2_stall_if #(
    parameter int WIDTH = 32
);
    logic             div_enE;
    logic             signedE;
    logic [WIDTH-1:0] src_aE;
    logic [WIDTH-1:0] src_bE;
    logic             flushE;
    logic             stall_otherE;
    logic             div_stallE;
    logic             div_validE;
    logic [WIDTH-1:0] hiE;
    logic [WIDTH-1:0] loE;

    modport master (
        output div_enE, signedE, src_aE, src_bE, flushE, stall_otherE,
        input  div_stallE, div_validE, hiE, loE
    );

    modport slave (
        input  div_enE, signedE, src_aE, src_bE, flushE, stall_otherE,
        output div_stallE, div_validE, hiE, loE
    );
endinterface
`default_nettype wire

// File: rtl/div_radix2_stall.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_radix2_stall : multi-cycle restoring DIV/DIVU with stall handshake|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_radix2_stall #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    div_radix2_stall_if.slave        bus
);
    localparam int        CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             w_kill;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_kill     = bus.flushE | ~bus.div_enE;
    assign w_last     = (cnt_q == CW'(WIDTH - 1));
    assign w_shift    = {rem_q, dvd_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_rem_step = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_step = {dvd_q[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_abs_a    = (bus.signedE & bus.src_aE[WIDTH-1]) ? -bus.src_aE : bus.src_aE;
    assign w_abs_b    = (bus.signedE & bus.src_bE[WIDTH-1]) ? -bus.src_bE : bus.src_bE;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush/abort outranks completion and hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.div_enE & ~bus.flushE) state_d = S_BUSY;
            S_BUSY: begin
                if (w_kill)      state_d = S_IDLE;
                else if (w_last) state_d = S_DONE;
            end
            S_DONE: if (w_kill | ~bus.stall_otherE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.div_stallE = bus.div_enE & ~bus.flushE &
                         ((state_q == S_IDLE) | (state_q == S_BUSY));
        bus.div_validE = (state_q == S_DONE);
        bus.hiE        = hi_q;
        bus.loE        = lo_q;
    end

    // Datapath next-state: operands latched every IDLE cycle, one step per BUSY cycle
    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        sq_d  = sq_q;
        sr_d  = sr_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                rem_d = '0;
                dvd_d = w_abs_a;
                dvs_d = w_abs_b;
                sq_d  = bus.signedE & (bus.src_aE[WIDTH-1] ^ bus.src_bE[WIDTH-1]);
                sr_d  = bus.signedE & bus.src_aE[WIDTH-1];
            end
            S_BUSY: begin
                if (!w_kill) begin
                    cnt_d = cnt_q + CW'(1);
                    rem_d = w_rem_step;
                    dvd_d = w_quo_step;
                    if (w_last) begin
                        lo_d = sq_q ? -w_quo_step : w_quo_step;
                        hi_d = sr_q ? -w_rem_step : w_rem_step;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            sq_q  <= 1'b0;
            sr_q  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            sq_q  <= sq_d;
            sr_q  <= sr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule
`default_nettype wire
